// File: rtl/tetris_pkg.sv
// Shared playfield geometry, colour codes, the line-clear FSM state type and a saturating adder.
// Latency: none (declarations only).
// Backpressure: not applicable.
package tetris_pkg;

    localparam int ROWS = 20;
    localparam int COLS = 10;
    localparam int CW   = 4;

    localparam logic [CW-1:0] EMPTY_CODE = 4'd0;
    localparam logic [CW-1:0] CODE_I     = 4'd1;
    localparam logic [CW-1:0] CODE_O     = 4'd2;
    localparam logic [CW-1:0] CODE_T     = 4'd3;
    localparam logic [CW-1:0] CODE_S     = 4'd4;
    localparam logic [CW-1:0] CODE_Z     = 4'd5;
    localparam logic [CW-1:0] CODE_J     = 4'd6;
    localparam logic [CW-1:0] CODE_L     = 4'd7;

    typedef enum logic [2:0] {
        IDLE,
        SCAN_RD,
        SCAN_CHK,
        SHIFT_RD,
        SHIFT_WR,
        CLEAR_TOP,
        DONE
    } lc_state_t;

    // Adds a per-pass line count to the running total, pinning at all-ones instead of wrapping.
    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [4:0] b);
        logic [16:0] sum;
        sum = {1'b0, a} + {12'd0, b};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

endpackage

// File: rtl/line_clear_ctrl_row_full_detect.sv
// Reduces one playfield row word to a single "every cell occupied" flag.
// Latency: purely combinational.
// Backpressure: none; output follows the input word.
module row_full_detect #(
    parameter int COLS = 10,
    parameter int CW   = 4
) (
    input  logic [COLS*CW-1:0] row,
    output logic               full
);

    // A single empty (zero) cell anywhere makes the row not full.
    always_comb begin
        full = 1'b1;
        for (int c = 0; c < COLS; c++) begin
            if (row[c*CW +: CW] == '0) begin
                full = 1'b0;
            end
        end
    end

endmodule

// File: rtl/line_clear_ctrl.sv
// Scans the playfield bottom-up after a lock, collapses every full row and counts lines cleared.
// Latency: 2 cycles per scanned row, 2 per shifted row, 1 per top-row clear, plus the DONE cycle.
// Backpressure: owns the row RAM while busy; start outside IDLE is dropped, never queued.
import tetris_pkg::*;

module line_clear_ctrl (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [4:0]           lines_cleared,
    output logic [15:0]          total_lines,
    output logic [4:0]           rd_addr,
    input  logic [COLS*CW-1:0]   rd_data,
    output logic                 wr_en,
    output logic [4:0]           wr_addr,
    output logic [COLS*CW-1:0]   wr_data
);

    localparam logic [4:0] ROW_LAST = 5'(ROWS - 1);

    lc_state_t   state, state_nxt;
    logic [4:0]  r, r_nxt;
    logic [4:0]  s, s_nxt;
    logic [4:0]  n, n_nxt;
    logic [4:0]  lines_q;
    logic [15:0] total_q;
    logic [15:0] total_sum;
    logic        row_full;

    row_full_detect #(
        .COLS (COLS),
        .CW   (CW)
    ) u_row_full (
        .row  (rd_data),
        .full (row_full)
    );

    assign total_sum = sat_add16(total_q, n);

    // The pass results become visible in the DONE cycle itself and are then held in registers.
    assign lines_cleared = (state == DONE) ? n         : lines_q;
    assign total_lines   = (state == DONE) ? total_sum : total_q;

    // State, scan/shift pointers, per-pass counter and the held results.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            r       <= '0;
            s       <= '0;
            n       <= '0;
            lines_q <= '0;
            total_q <= '0;
        end else begin
            state <= state_nxt;
            r     <= r_nxt;
            s     <= s_nxt;
            n     <= n_nxt;
            if (state == DONE) begin
                lines_q <= n;
                total_q <= total_sum;
            end
        end
    end

    // Next-state and RAM port control; the RAM port is idle (all zero) outside its owning states.
    always_comb begin
        state_nxt = state;
        r_nxt     = r;
        s_nxt     = s;
        n_nxt     = n;
        busy      = 1'b0;
        done      = 1'b0;
        rd_addr   = '0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    r_nxt     = ROW_LAST;
                    n_nxt     = '0;
                    state_nxt = SCAN_RD;
                end
            end
            SCAN_RD: begin
                busy      = 1'b1;
                rd_addr   = r;
                state_nxt = SCAN_CHK;
            end
            SCAN_CHK: begin
                busy = 1'b1;
                if (row_full) begin
                    n_nxt     = n + 5'd1;
                    s_nxt     = r;
                    // Row 0 has nothing above it to pull down; go straight to blanking it.
                    state_nxt = (r == '0) ? CLEAR_TOP : SHIFT_RD;
                end else if (r == '0) begin
                    state_nxt = DONE;
                end else begin
                    r_nxt     = r - 5'd1;
                    state_nxt = SCAN_RD;
                end
            end
            SHIFT_RD: begin
                busy      = 1'b1;
                rd_addr   = s - 5'd1;
                state_nxt = SHIFT_WR;
            end
            SHIFT_WR: begin
                busy      = 1'b1;
                wr_en     = 1'b1;
                wr_addr   = s;
                wr_data   = rd_data;
                s_nxt     = s - 5'd1;
                state_nxt = (s == 5'd1) ? CLEAR_TOP : SHIFT_RD;
            end
            CLEAR_TOP: begin
                busy      = 1'b1;
                wr_en     = 1'b1;
                // r is left alone: the row that just dropped into r must be checked too.
                state_nxt = SCAN_RD;
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
